// File: rtl/conv_stream_pkg.sv
// conv_stream_pkg: shared state encoding and saturating arithmetic for the streaming conv block
package conv_stream_pkg;

    typedef enum logic [1:0] {S_LOADF, S_IN, S_MAC, S_OUT} state_t;

    // Wide enough to hold a full-precision product of two 32-bit operands
    typedef logic signed [63:0] wide_t;

    function automatic wide_t sat_max(input int w);
        return (wide_t'(1) <<< (w - 1)) - wide_t'(1);
    endfunction

    function automatic wide_t sat_min(input int w);
        return -sat_max(w) - wide_t'(1);
    endfunction

    function automatic wide_t sat_clamp(input wide_t v, input int w);
        return v > sat_max(w) ? sat_max(w) : (v < sat_min(w) ? sat_min(w) : v);
    endfunction

    function automatic wide_t sat_mul(input wide_t a, input wide_t b, input int w);
        return sat_clamp(a * b, w);
    endfunction

    function automatic wide_t sat_add(input wide_t a, input wide_t b, input int w);
        return sat_clamp(a + b, w);
    endfunction

endpackage

// File: rtl/conv1d_stream_p_lane.sv
// conv_sat_lane: one saturating product plus one saturating add into the running partial sum
module conv_sat_lane
    import conv_stream_pkg::*;
#(
    parameter int T = 16
) (
    input  logic signed [T-1:0] a,
    input  logic signed [T-1:0] b,
    input  logic signed [T-1:0] prod_in,
    input  logic signed [T-1:0] psum_in,
    output logic signed [T-1:0] prod,
    output logic signed [T-1:0] psum_out
);

    assign prod     = T'(sat_mul(wide_t'(a), wide_t'(b), T));
    assign psum_out = T'(sat_add(wide_t'(psum_in), wide_t'(prod_in), T));

endmodule

// File: rtl/conv1d_stream_p.sv
// conv1d_stream_p: streaming valid-mode 1-D correlation with loadable filter and P saturating MAC lanes
module conv1d_stream_p
    import conv_stream_pkg::*;
#(
    parameter int T      = 16,
    parameter int SIZE_F = 4,
    parameter int SIZE_X = 16,
    parameter int P      = 1,
    parameter int RELU   = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic signed [T-1:0] x_data,
    input  logic                x_valid,
    output logic                x_ready,
    input  logic signed [T-1:0] f_data,
    input  logic                f_valid,
    output logic                f_ready,
    output logic signed [T-1:0] y_data,
    output logic                y_valid,
    input  logic                y_ready,
    output logic                y_last
);

    localparam int K  = SIZE_F / P;
    localparam int FW = $clog2(SIZE_F + 1);
    localparam int XW = $clog2(SIZE_X + 1);
    localparam int MW = $clog2(K + 2);

    state_t state, state_nx;
    logic signed [T-1:0] coef [SIZE_F];
    logic signed [T-1:0] win [SIZE_F];
    logic signed [T-1:0] ops_x [SIZE_F];
    logic signed [T-1:0] ops_f [SIZE_F];
    logic signed [T-1:0] prod_r [P];
    logic signed [T-1:0] prod_c [P];
    logic signed [T-1:0] chain [P+1];
    logic signed [T-1:0] acc;
    logic [FW-1:0] fcnt, wcnt, wcnt_inc;
    logic [XW-1:0] xcnt;
    logic [MW-1:0] mcnt;
    logic f_xfer, x_xfer, y_xfer, boundary;

    assign f_xfer   = f_valid && f_ready;
    assign x_xfer   = x_valid && x_ready;
    assign y_xfer   = y_valid && y_ready;
    assign boundary = xcnt == '0;
    assign wcnt_inc = (wcnt == FW'(SIZE_F)) ? wcnt : wcnt + 1'b1;
    assign chain[0] = acc;

    for (genvar l = 0; l < P; l++) begin : g_lane
        conv_sat_lane #(.T(T)) u_lane (
            .a        (ops_x[l]),
            .b        (ops_f[l]),
            .prod_in  (prod_r[l]),
            .psum_in  (chain[l]),
            .prod     (prod_c[l]),
            .psum_out (chain[l+1])
        );
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_LOADF;
        else       state <= state_nx;
    end

    // Next-state logic; a pending filter at a frame boundary wins over x
    always_comb begin
        state_nx = state;
        case (state)
            S_LOADF: if (f_xfer && fcnt == FW'(SIZE_F - 1)) state_nx = S_IN;
            S_IN:    if (boundary && f_valid) state_nx = S_LOADF;
                     else if (x_xfer && wcnt_inc == FW'(SIZE_F)) state_nx = S_MAC;
            S_MAC:   if (mcnt == MW'(K + 1)) state_nx = S_OUT;
            S_OUT:   if (y_xfer) state_nx = S_IN;
            default: state_nx = S_LOADF;
        endcase
    end

    // Handshake outputs; x_ready is withheld at a boundary so a reload is not raced by x
    always_comb begin
        f_ready = state == S_LOADF;
        x_ready = state == S_IN && !(boundary && f_valid);
        y_valid = state == S_OUT;
        y_last  = state == S_OUT && xcnt == XW'(SIZE_X);
    end

    // Coefficient load, sliding window, operand issue shifter, product stage, accumulator, result
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SIZE_F; i++) begin
                coef[i]  <= '0;
                win[i]   <= '0;
                ops_x[i] <= '0;
                ops_f[i] <= '0;
            end
            for (int i = 0; i < P; i++) prod_r[i] <= '0;
            fcnt   <= '0;
            wcnt   <= '0;
            xcnt   <= '0;
            mcnt   <= '0;
            acc    <= '0;
            y_data <= '0;
        end else begin
            if (f_xfer) begin
                for (int i = 0; i < SIZE_F; i++) if (fcnt == FW'(i)) coef[i] <= f_data;
                fcnt <= (fcnt == FW'(SIZE_F - 1)) ? '0 : fcnt + 1'b1;
            end
            if (x_xfer) begin
                for (int i = 0; i < SIZE_F - 1; i++) begin
                    win[i]   <= win[i+1];
                    ops_x[i] <= win[i+1];
                end
                win[SIZE_F-1]   <= x_data;
                ops_x[SIZE_F-1] <= x_data;
                for (int i = 0; i < SIZE_F; i++) ops_f[i] <= coef[i];
                xcnt <= xcnt + 1'b1;
                wcnt <= wcnt_inc;
                mcnt <= '0;
                acc  <= '0;
            end
            if (state == S_MAC) begin
                mcnt <= mcnt + 1'b1;
                if (mcnt < MW'(K)) begin
                    for (int i = 0; i < P; i++) prod_r[i] <= prod_c[i];
                    for (int i = 0; i < SIZE_F - P; i++) begin
                        ops_x[i] <= ops_x[i+P];
                        ops_f[i] <= ops_f[i+P];
                    end
                end
                if (mcnt != '0 && mcnt <= MW'(K)) acc <= chain[P];
                if (mcnt == MW'(K + 1)) y_data <= (RELU != 0 && acc < 0) ? '0 : acc;
            end
            if (y_xfer && y_last) begin
                xcnt <= '0;
                wcnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_conv1d_stream_p.sv
// tb_conv1d_stream_p: randomized self-checking bench over four lane/ReLU configurations
module tb_conv1d_stream_p;

    localparam int SF = 4;
    localparam int SX = 16;
    localparam int NY = SX - SF + 1;
    localparam int ND = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic signed [15:0] x_data [ND];
    logic signed [15:0] f_data [ND];
    logic signed [15:0] y_data [ND];
    logic x_valid [ND];
    logic f_valid [ND];
    logic y_ready [ND];
    logic x_ready [ND];
    logic f_ready [ND];
    logic y_valid [ND];
    logic y_last  [ND];

    int compared = 0;
    int mismatched = 0;
    int fco [SF];
    int xs [SX];
    longint ys [NY];

    always #5 clk = ~clk;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        conv1d_stream_p #(
            .T(16), .SIZE_F(SF), .SIZE_X(SX),
            .P(g == 0 ? 1 : g == 1 ? 2 : g == 2 ? 4 : 2),
            .RELU(g == 3 ? 0 : 1)
        ) u_dut (
            .clk     (clk),
            .reset   (reset),
            .x_data  (x_data[g]),
            .x_valid (x_valid[g]),
            .x_ready (x_ready[g]),
            .f_data  (f_data[g]),
            .f_valid (f_valid[g]),
            .f_ready (f_ready[g]),
            .y_data  (y_data[g]),
            .y_valid (y_valid[g]),
            .y_ready (y_ready[g]),
            .y_last  (y_last[g])
        );
    end

    function automatic int lanes(input int s);
        return s == 0 ? 1 : s == 1 ? 2 : s == 2 ? 4 : 2;
    endfunction

    function automatic bit relu_of(input int s);
        return s != 3;
    endfunction

    function automatic longint sat16(input longint v);
        return v > 32767 ? 32767 : (v < -32768 ? -32768 : v);
    endfunction

    // Reference: saturating correlation straight from the arithmetic rules
    function automatic longint ref_y(input int n, input bit relu);
        longint a = 0;
        for (int j = 0; j < SF; j++) a = sat16(a + sat16(longint'(xs[n+j]) * longint'(fco[j])));
        return (relu && a < 0) ? 0 : a;
    endfunction

    task automatic check(input string tag, input longint got, input longint exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_f(input int a, input int b, input int c, input int d);
        fco[0] = a; fco[1] = b; fco[2] = c; fco[3] = d;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic load_f(input int sel, input bit with_x);
        int fi = 0;
        bit facc = 0;
        for (int c = 0; c < 40 && fi < SF; c++) begin
            @(negedge clk);
            if (facc) fi++;
            f_valid[sel] = fi < SF;
            if (fi < SF) f_data[sel] = 16'(fco[fi]);
            x_valid[sel] = with_x && fi < SF;
            x_data[sel] = 16'sd7;
            #1;
            if (with_x) check(fi < SF ? "pri_xrdy" : "pri_xrdy_after", longint'(x_ready[sel]), fi < SF ? 0 : 1);
            facc = f_valid[sel] && f_ready[sel];
        end
        f_valid[sel] = 1'b0;
        x_valid[sel] = 1'b0;
        check("f_loaded", fi, SF);
    endtask

    task automatic run_frame(input int sel, input int hold, input bit rnd);
        int xi = 0, yi = 0, acc_it = -1000, hold_left = hold;
        bit xacc = 0, yacc = 0, lat_done = 0;
        for (int it = 0; it < 2000 && yi < NY; it++) begin
            @(negedge clk);
            if (xacc) begin
                xi++;
                if (xi == SF) acc_it = it;
            end
            if (yacc) yi++;
            if (yi == NY) break;
            if (y_valid[sel] && yi == 0 && !lat_done) begin
                check("latency", it - acc_it, SF / lanes(sel) + 2);
                lat_done = 1;
            end
            x_valid[sel] = xi < SX && (!rnd || $urandom_range(0, 3) != 0);
            if (xi < SX) x_data[sel] = 16'(xs[xi]);
            if (y_valid[sel] && yi == 0 && hold_left > 0) begin
                y_ready[sel] = 1'b0;
                hold_left--;
                #1;
                check("hold_y", y_data[sel], ref_y(0, relu_of(sel)));
                check("hold_xrdy", longint'(x_ready[sel]), 0);
                check("hold_xcnt", xi, SF);
            end else begin
                y_ready[sel] = !rnd || $urandom_range(0, 1) == 1;
                #1;
            end
            xacc = x_valid[sel] && x_ready[sel];
            yacc = y_valid[sel] && y_ready[sel];
            if (yacc) begin
                check("y", y_data[sel], ref_y(yi, relu_of(sel)));
                check("y_last", longint'(y_last[sel]), yi == NY - 1 ? 1 : 0);
                ys[yi] = y_data[sel];
            end
        end
        x_valid[sel] = 1'b0;
        y_ready[sel] = 1'b0;
        check("y_count", yi, NY);
        check("x_count", xi, SX);
    endtask

    initial begin
        int xi;
        bit xacc;
        for (int s = 0; s < ND; s++) begin
            x_valid[s] = 0; f_valid[s] = 0; y_ready[s] = 0;
            x_data[s] = '0; f_data[s] = '0;
        end
        for (int s = 0; s < ND; s++) begin
            do_reset();
            #1;
            check("rst_yv", longint'(y_valid[s]), 0);
            check("rst_yd", y_data[s], 0);
            check("rst_yl", longint'(y_last[s]), 0);
            check("rst_fr", longint'(f_ready[s]), 1);
            check("rst_xr", longint'(x_ready[s]), 0);

            set_f(67, 202, 179, 191);
            load_f(s, 0);
            for (int i = 0; i < SX; i++) xs[i] = i + 1;
            run_frame(s, 0, 0);
            check("y0_const", ys[0], 1772);
            check("y12_const", ys[NY-1], 9440);
            run_frame(s, 10, 0);

            set_f(32767, 32767, 32767, 32767);
            load_f(s, 1);
            for (int i = 0; i < SX; i++) xs[i] = 32767;
            run_frame(s, 0, 0);
            for (int i = 0; i < SX; i++) xs[i] = -32768;
            run_frame(s, 0, 1);

            set_f(67, 202, 179, 191);
            load_f(s, 1);
            for (int i = 0; i < SX; i++) xs[i] = -1;
            run_frame(s, 0, 1);

            for (int r = 0; r < 2; r++) begin
                for (int j = 0; j < SF; j++)
                    fco[j] = r == 0 ? int'($urandom_range(0, 400)) - 200 : int'($urandom_range(0, 65535)) - 32768;
                load_f(s, 1);
                for (int i = 0; i < SX; i++)
                    xs[i] = r == 0 ? int'($urandom_range(0, 400)) - 200 : int'($urandom_range(0, 65535)) - 32768;
                run_frame(s, 0, 1);
            end

            set_f(67, 202, 179, 191);
            load_f(s, 1);
            xi = 0;
            xacc = 0;
            for (int c = 0; c < 40 && xi < SF; c++) begin
                @(negedge clk);
                if (xacc) xi++;
                x_valid[s] = xi < SF;
                x_data[s] = 16'(xi + 1);
                #1;
                xacc = x_valid[s] && x_ready[s];
            end
            check("mac_feed", xi, SF);
            @(negedge clk);
            #1;
            reset = 1'b1;
            #1;
            check("arst_yv", longint'(y_valid[s]), 0);
            check("arst_fr", longint'(f_ready[s]), 1);
            check("arst_xr", longint'(x_ready[s]), 0);
            @(negedge clk);
            reset = 1'b0;
            set_f(1, 0, 0, 0);
            load_f(s, 0);
            for (int i = 0; i < SX; i++) xs[i] = i + 1;
            run_frame(s, 0, 0);
            check("post_rst_y0", ys[0], 1);
            check("post_rst_y12", ys[NY-1], 13);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
